// File: rtl/bitgen_pkg.sv
// Shared definitions for the bit pattern generator.
//   W  : width of emitted numbers
//   CW : width of the ones/length count inputs
//   state_t        : FSM encoding (IDLE, EMIT)
//   params_legal   : start-parameter legality check
//   first_value    : smallest number with the requested counts
//   window_mask    : mask of the b-1 bits below the fixed MSB
package bitgen_pkg;

  localparam int W  = 16;
  localparam int CW = $clog2(W + 1);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // 1 <= len <= W and 1 <= ones <= len
  function automatic logic params_legal(input logic [CW-1:0] ones,
                                        input logic [CW-1:0] len);
    return (len != '0) && (len <= CW'(W)) && (ones != '0) && (ones <= len);
  endfunction

  // MSB at b-1, remaining o-1 ones packed at the bottom.
  function automatic logic [W-1:0] first_value(input logic [CW-1:0] ones,
                                               input logic [CW-1:0] len);
    logic [W-1:0] msb;
    logic [W-1:0] low;
    msb = W'(1) << (len - CW'(1));
    low = (W'(1) << (ones - CW'(1))) - W'(1);
    return msb | low;
  endfunction

  // Bits [len-2:0]; zero when len==1.
  function automatic logic [W-1:0] window_mask(input logic [CW-1:0] len);
    return (W'(1) << (len - CW'(1))) - W'(1);
  endfunction

endpackage

// File: rtl/bit_pattern_generator_next_pattern.sv
// next_pattern: combinational successor for the pattern stream.
// Applies Gosper's next-permutation step to the b-1 bits below the fixed
// MSB, keeping bit b-1 set and all higher bits clear.
//   i_value : current pattern (W)
//   i_len   : bit-length b (CW)
//   o_next  : next greater pattern with the same counts (W)
//   o_last  : i_value is the final pattern for this (o, b)
module next_pattern
  import bitgen_pkg::*;
(
  input  logic [W-1:0]  i_value,
  input  logic [CW-1:0] i_len,
  output logic [W-1:0]  o_next,
  output logic          o_last
);

  localparam int TZW = $clog2(W);

  logic [W-1:0]   w_mask;
  logic [W-1:0]   w_msb;
  logic [W-1:0]   w_x;
  logic [W-1:0]   w_c;
  logic [W-1:0]   w_r;
  logic [W-1:0]   w_spread;
  logic [TZW-1:0] w_tz;

  assign w_mask = window_mask(i_len);
  assign w_msb  = W'(1) << (i_len - CW'(1));
  assign w_x    = i_value & w_mask;
  // Lowest set bit, then ripple it up; x <= 2^(W-1)-1 so r never overflows W.
  assign w_c    = w_x & (~w_x + W'(1));
  assign w_r    = w_x + w_c;

  // Trailing-zero count replaces the divide-by-c of the textbook step.
  always_comb begin
    w_tz = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (w_x[i]) w_tz = TZW'(i);
    end
  end

  assign w_spread = ((w_r ^ w_x) >> 2) >> w_tz;
  assign o_next   = ((w_spread | w_r) & w_mask) | w_msb;

  // Last when the window holds no ones (o==1) or when the carry escapes the
  // window, i.e. the low o-1 ones already sit at the top of the window.
  assign o_last = (w_x == '0) || ((w_r & ~w_mask) != '0);

endmodule

// File: rtl/bit_pattern_generator.sv
// bit_pattern_generator: streams, in ascending order, every W-bit number
// whose popcount is ones_in and whose bit-length is len_in.
//   clk, rst          : clock, synchronous active-high reset
//   start             : begin an enumeration (honoured only in IDLE)
//   ones_in, len_in   : requested ones-count o and bit-length b
//   out_num/out_index : current pattern and its zero-based beat number
//   out_valid/ready   : beat handshake; out_last flags the final beat
//   busy              : enumeration in progress
//   done / err        : one-cycle pulses (finished / illegal start)
module bit_pattern_generator
  import bitgen_pkg::*;
#(
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] ones_in,
  input  logic [CW-1:0] len_in,
  output logic [W-1:0]  out_num,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic [IW-1:0] out_index,
  output logic          busy,
  output logic          done,
  output logic          err
);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_num;
  logic [IW-1:0]  r_idx;
  logic [CW-1:0]  r_len;
  logic           r_done;
  logic           r_err;

  logic [W-1:0]   w_next;
  logic           w_last;
  logic           w_legal;
  logic           w_xfer;

  next_pattern u_next (
    .i_value (r_num),
    .i_len   (r_len),
    .o_next  (w_next),
    .o_last  (w_last)
  );

  assign w_legal = params_legal(ones_in, len_in);
  assign w_xfer  = (r_state == EMIT) && out_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && w_legal) w_state_nxt = EMIT;
      end
      EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = w_last;
        if (w_xfer && w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Only the length is latched: the ones-count is implied by the pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_num  <= '0;
      r_idx  <= '0;
      r_len  <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_legal) begin
              r_len <= len_in;
              r_num <= first_value(ones_in, len_in);
              r_idx <= '0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (w_xfer) begin
            if (w_last) begin
              r_done <= 1'b1;
            end else begin
              r_num <= w_next;
              r_idx <= r_idx + IW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_num   = r_num;
  assign out_index = r_idx;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_bit_pattern_generator.sv
module tb_bit_pattern_generator;
  import bitgen_pkg::*;

  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] ones_in = '0;
  logic [CW-1:0] len_in = '0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_num;
  logic          out_valid;
  logic          out_last;
  logic [IW-1:0] out_index;
  logic          busy;
  logic          done;
  logic          err;

  bit_pattern_generator #(.IW(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .ones_in(ones_in), .len_in(len_in),
    .out_num(out_num), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_index(out_index), .busy(busy), .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  int           exp_idx;
  int           beats;
  int           cur_o, cur_b;
  logic [W-1:0] prev_num;
  logic [W-1:0] last_num;
  int           last_idx;
  bit           mon_en = 1'b0;

  // Reference bit counter: ones-count and bit-length.
  function automatic int popc(input logic [W-1:0] v);
    int n = 0;
    for (int i = 0; i < W; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic int blen(input logic [W-1:0] v);
    int n = 0;
    for (int i = 0; i < W; i++) if (v[i]) n = i + 1;
    return n;
  endfunction

  // Brute-force expected stream: scan all values in ascending order.
  task automatic build(input int b, input int o);
    logic [W-1:0] tv;
    exp_q.delete();
    for (int v = 1; v < (1 << W); v++) begin
      tv = v[W-1:0];
      if (popc(tv) == o && blen(tv) == b) exp_q.push_back(tv);
    end
    cur_b = b; cur_o = o; exp_idx = 0; beats = 0; prev_num = '0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Pulse start for one cycle, then scramble the inputs to prove latching.
  task automatic kick(input int b, input int o);
    start = 1'b1; ones_in = CW'(o); len_in = CW'(b);
    cyc();
    start = 1'b0; ones_in = CW'(2); len_in = CW'(3);
  endtask

  // Scoreboard: pop one expected beat for every accepted beat.
  initial begin
    logic [W-1:0] e;
    logic         e_last;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_beat num=%h idx=%0d expected no beat", out_num, out_index);
        end else begin
          e = exp_q.pop_front();
          e_last = (exp_q.size() == 0);
          if (out_num !== e || out_index !== IW'(exp_idx) || out_last !== e_last) begin
            errors++;
            $display("FAIL beat num=%h idx=%0d last=%b expected num=%h idx=%0d last=%b",
                     out_num, out_index, out_last, e, exp_idx, e_last);
          end
        end
        checks++;
        if (beats > 0 && out_num <= prev_num) begin
          errors++;
          $display("FAIL ascending got %h after %h", out_num, prev_num);
        end
        checks++;
        if (popc(out_num) != cur_o || blen(out_num) != cur_b) begin
          errors++;
          $display("FAIL counter num=%h o=%0d b=%0d expected o=%0d b=%0d",
                   out_num, popc(out_num), blen(out_num), cur_o, cur_b);
        end
        prev_num = out_num; last_num = out_num; last_idx = int'(out_index);
        exp_idx++; beats++;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cyc();
    checks++;
    if ({out_valid, busy, done, err, out_last} !== 5'b0 || out_num !== '0 || out_index !== '0) begin
      errors++;
      $display("FAIL reset valid=%b busy=%b done=%b err=%b last=%b num=%h idx=%0d expected all 0",
               out_valid, busy, done, err, out_last, out_num, out_index);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_basic(input int b, input int o, input string name);
    bit got = 0;
    build(b, o);
    out_ready = 1'b1;
    kick(b, o);
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_latency valid=%b busy=%b expected 1 1", name, out_valid, busy);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
    end
    checks++;
    if (!got || busy !== 1'b0 || out_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_done got=%b busy=%b valid=%b left=%0d expected 1 0 0 0",
               name, got, busy, out_valid, exp_q.size());
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_pulse done=%b expected 0", name, done);
    end
    cyc();
  endtask

  task automatic test_illegal();
    int ob[4][2] = '{'{3, 2}, '{0, 5}, '{1, 17}, '{1, 0}};
    out_ready = 1'b1;
    foreach (ob[k]) begin
      exp_q.delete();
      kick(ob[k][1], ob[k][0]);
      checks++;
      if (err !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL illegal_err o=%0d b=%0d err=%b valid=%b expected 1 0",
                 ob[k][0], ob[k][1], err, out_valid);
      end
      cyc();
      checks++;
      if (err !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL illegal_pulse o=%0d b=%0d err=%b valid=%b expected 0 0",
                 ob[k][0], ob[k][1], err, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    bit got = 0;
    build(5, 3);
    out_ready = 1'b0;
    kick(5, 3);
    for (int i = 0; i < 4; i++) begin
      // start while busy must be ignored
      start = 1'b1; ones_in = CW'(1); len_in = CW'(2);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_num !== 16'h0013 || out_index !== '0) begin
        errors++;
        $display("FAIL hold valid=%b num=%h idx=%0d expected 1 0013 0", out_valid, out_num, out_index);
      end
      cyc();
    end
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      out_ready = (i % 2 == 0);
      @(negedge clk);
      if (done) begin got = 1; break; end
      cyc();
    end
    checks++;
    if (!got || last_idx != 5 || last_num !== 16'h001C || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_end done=%b idx=%0d num=%h left=%0d expected 1 5 001c 0",
               got, last_idx, last_num, exp_q.size());
    end
    cyc();
  endtask

  task automatic test_reset_midrun();
    bit reached = 0;
    bit saw_done = 0;
    build(16, 8);
    out_ready = 1'b1;
    kick(16, 8);
    for (int i = 0; i < 300; i++) begin
      if (beats >= 100) begin reached = 1; break; end
      cyc();
    end
    checks++;
    if (!reached || out_index !== IW'(100)) begin
      errors++;
      $display("FAIL midrun_reach reached=%b idx=%0d expected 1 100", reached, out_index);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    exp_q.delete();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset valid=%b busy=%b done=%b expected 0 0 0", out_valid, busy, done);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL midrun_done done seen=1 expected 0");
    end
    cyc();
    out_ready = 1'b0;
    build(16, 8);
    kick(16, 8);
    checks++;
    if (out_valid !== 1'b1 || out_num !== 16'h807F || out_index !== '0) begin
      errors++;
      $display("FAIL restart valid=%b num=%h idx=%0d expected 1 807f 0", out_valid, out_num, out_index);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    exp_q.delete();
    cyc();
  endtask

  task automatic test_exhaustive();
    bit got = 0;
    build(16, 8);
    kick(16, 8);
    for (int i = 0; i < 40000; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (done) begin got = 1; break; end
      cyc();
    end
    checks++;
    if (!got || beats != 6435 || last_idx != 6434 || last_num !== 16'hFF00 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL exhaustive done=%b beats=%0d idx=%0d num=%h left=%0d expected 1 6435 6434 ff00 0",
               got, beats, last_idx, last_num, exp_q.size());
    end
    cyc();
  endtask

  initial begin
    test_reset();
    mon_en = 1'b1;
    test_basic(4, 2, "b4o2");
    test_basic(1, 1, "b1o1");
    test_basic(16, 16, "b16o16");
    test_basic(16, 1, "b16o1");
    test_illegal();
    test_backpressure();
    test_reset_midrun();
    test_exhaustive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_pattern_generator.md
Name: bit_pattern_generator

Overview:
- Inverse of the population/bit-length counter in the Four-digit Increment & Decrement design.
- The counter takes a number and reports its counts. This block takes a requested ones-count and bit-length and streams every W-bit number that has exactly those counts.
- Values are emitted in ascending order over a valid/ready handshake.
- It feeds display/test stimulus paths. Every emitted value, checked by the counter, returns o == ones_in and b == len_in.

Parameters:
- W, 16, data width of emitted numbers.
- CW, $clog2(W+1) = 5, width of count inputs.
- IW, 16, width of the out_index beat counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new enumeration; sampled only in IDLE.
- ones_in  in  CW  required number of 1 bits (o).
- len_in  in  CW  required bit-length (b): MSB set at position b-1, all higher bits 0.
- out_num  out  W  current pattern.
- out_valid  out  1  out_num/out_index/out_last are valid.
- out_ready  in  1  consumer accepts the beat.
- out_last  out  1  current beat is the final pattern.
- out_index  out  IW  zero-based beat number within the enumeration.
- busy  out  1  high in EMIT.
- done  out  1  one-cycle pulse after the last beat is accepted.
- err  out  1  one-cycle pulse on start with illegal parameters.

Behaviour:
- Reset (rst=1 at a clk edge) forces IDLE and sets all outputs to 0. This applies mid-enumeration: any pending beat is dropped, and no done pulse is issued.
- States:
  - IDLE: busy=0, out_valid=0.
  - EMIT: busy=1, out_valid=1.
- Parameter legality on start:
  - Legal: 1 <= len_in <= W and 1 <= ones_in <= len_in.
  - Legal start in IDLE: params are latched, and the first value is (1<<(b-1)) | ((1<<(o-1))-1). out_index=0, next state EMIT. out_valid rises the cycle after start (latency 1).
  - Illegal start in IDLE: err=1 for exactly one cycle, stay IDLE, out_valid stays 0.
- start in EMIT is ignored. Latched parameters are unaffected by input changes after the start cycle.
- Handshake in EMIT:
  - Beat transfers when out_valid && out_ready.
  - Without transfer, out_num, out_index and out_last are held stable.
  - Transfer with out_last=0: out_num becomes the next greater value with the same bit 1..(b-2) popcount (o-1) in bits [b-2:0]. Bit b-1 stays set; bits above b-1 stay 0. out_index increments.
  - Transfer with out_last=1: next state IDLE, done=1 for one cycle, out_valid=0.
- out_last is combinational from the state register. It is 1 when the low o-1 set bits occupy positions [b-2 : b-o], i.e. the top o bits of the b-bit window are set.
- Single-beat cases:
  - o==1: only 1<<(b-1).
  - o==b: only (1<<b)-1.
  - For both, out_last=1 on beat 0.
- Total beats = C(b-1, o-1); the maximum is C(15,7)=6435, which fits IW.
- Successor: Gosper's step restricted to the b-1 low bits. It is purely combinational with no divider; trailing-zero count is done via a priority encoder.
- start with rst asserted in the same cycle: reset wins.

Decomposition:
- Shared package bitgen_pkg:
  - state enum {IDLE, EMIT}
  - W and CW constants
  - function for the legality check
- One natural sub-module: next_pattern.
  - Combinational.
  - Inputs: current value (W), length b.
  - Outputs: successor value and is_last flag.
- Top module holds the FSM, parameter latches, index counter and handshake.

Test Plan:
- b=4, o=2, out_ready=1:
  - out_num = 0x0009, 0x000A, 0x000C, with out_index 0, 1, 2.
  - out_last only on 0x000C.
  - done pulses the cycle after; busy then returns to 0.
- b=1, o=1 -> one beat 0x0001 with out_last=1. Then b=16, o=16 -> one beat 0xFFFF with out_last=1.
- Illegal params:
  - o=3, b=2 -> err one cycle, out_valid never rises.
  - o=0, b=5 -> err.
  - b=17 -> err.
- Backpressure, b=5, o=3:
  - Hold out_ready=0 for 4 cycles on beat 0x0013: value and index stay stable.
  - Then toggle ready every other cycle: full sequence 0x13, 0x15, 0x16, 0x19, 0x1A, 0x1C, with index reaching 5.
- Reset mid-run: b=16, o=8, assert rst at beat 100 -> next cycle out_valid=0, busy=0, no done. A fresh start restarts at 0x807F with index 0.
- Exhaustive self-check:
  - b=16, o=8 with random ready: 6435 beats, strictly ascending, last = 0xFF00, last index 6434.
  - Each beat passed through the bit counter yields o=8, b=16.
